// File: rtl/pedal_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pedal_switch_ctrl
// Description : Footswitch debounce, effect-select sync, and a pop-free
//               mute -> switch -> settle -> unmute sequencer for the analog path.
// Revision    : 1.0 - initial release
// ============================================================================
module pedal_switch_ctrl #(
    parameter int DB_CYCLES   = 1024,
    parameter int MUTE_CYCLES = 256,
    parameter int CNT_W       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       fsw_n,
    input  logic [1:0] fx_sel,
    output logic       mute,
    output logic       bypass,
    output logic [3:0] fx_en,
    output logic       led,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MUTE_RAMP = 2'd1,
        S_SWITCH    = 2'd2,
        S_SETTLE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MUTE_LAST = CNT_W'(MUTE_CYCLES - 1);

    logic             r_fsw_s1;
    logic             r_fsw_s2;
    logic             r_fsw_db;
    logic [CNT_W-1:0] r_db_cnt;
    logic [1:0]       r_fx_s1;
    logic [1:0]       r_fx_s2;

    state_t           r_state;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [1:0]       r_cur_sel;
    logic             r_pending;
    logic             r_mute;
    logic             r_bypass;
    logic [3:0]       r_fx_en;
    logic             r_led;
    logic             r_busy;

    logic             w_rst;
    logic             w_db_diff;
    logic             w_db_done;
    logic             w_press;
    logic             w_sel_evt;
    logic             w_phase_done;
    logic             w_new_bypass;
    logic [3:0]       w_new_fx_en;

    assign w_rst        = !rst_n || !ena;
    assign w_db_diff    = (r_fsw_s2 != r_fsw_db);
    assign w_db_done    = w_db_diff && (r_db_cnt == C_DB_LAST);
    // Only the debounced 1->0 edge is a press; releases are ignored.
    assign w_press      = w_db_done && r_fsw_db;
    assign w_sel_evt    = (r_fx_s2 != r_cur_sel);
    assign w_phase_done = (r_phase_cnt == C_MUTE_LAST);
    assign w_new_bypass = r_bypass ^ r_pending;
    assign w_new_fx_en  = w_new_bypass ? 4'b0000 : (4'b0001 << r_fx_s2);

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_fsw_s1 <= 1'b1;
            r_fsw_s2 <= 1'b1;
            r_fsw_db <= 1'b1;
            r_db_cnt <= '0;
            r_fx_s1  <= 2'd0;
            r_fx_s2  <= 2'd0;
        end else begin
            r_fsw_s1 <= fsw_n;
            r_fsw_s2 <= r_fsw_s1;
            r_fx_s1  <= fx_sel;
            r_fx_s2  <= r_fx_s1;
            if (w_db_done) begin
                r_fsw_db <= ~r_fsw_db;
                r_db_cnt <= '0;
            end else if (w_db_diff) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= '0;
            r_cur_sel   <= 2'd0;
            r_pending   <= 1'b0;
            r_mute      <= 1'b0;
            r_bypass    <= 1'b1;
            r_fx_en     <= 4'b0000;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Presses combine by parity until the SWITCH cycle consumes them.
            r_pending <= r_pending ^ w_press;
            case (r_state)
                S_IDLE: begin
                    if (r_pending || w_sel_evt) begin
                        r_state     <= S_MUTE_RAMP;
                        r_phase_cnt <= '0;
                        r_mute      <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_MUTE_RAMP: begin
                    if (w_phase_done) begin
                        r_state     <= S_SWITCH;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                S_SWITCH: begin
                    r_bypass    <= w_new_bypass;
                    r_led       <= ~w_new_bypass;
                    r_fx_en     <= w_new_fx_en;
                    r_cur_sel   <= r_fx_s2;
                    // A press arriving in this very cycle belongs to the next sequence.
                    r_pending   <= w_press;
                    r_phase_cnt <= '0;
                    r_state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (w_phase_done) begin
                        r_state     <= S_IDLE;
                        r_phase_cnt <= '0;
                        r_mute      <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mute   = r_mute;
    assign bypass = r_bypass;
    assign fx_en  = r_fx_en;
    assign led    = r_led;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pedal_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pedal_switch_ctrl
// Description : Directed self-checking bench for pedal_switch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pedal_switch_ctrl;

    localparam int C_DB = 4;
    localparam int C_MC = 8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       fsw_n;
    logic [1:0] fx_sel;
    logic       mute;
    logic       bypass;
    logic [3:0] fx_en;
    logic       led;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    pedal_switch_ctrl #(
        .DB_CYCLES   (C_DB),
        .MUTE_CYCLES (C_MC),
        .CNT_W       (12)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .fsw_n  (fsw_n),
        .fx_sel (fx_sel),
        .mute   (mute),
        .bypass (bypass),
        .fx_en  (fx_en),
        .led    (led),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic m, input logic bs,
                            input logic b, input logic [3:0] f);
        chk({tag, ".mute"},   {3'b000, mute},   {3'b000, m});
        chk({tag, ".busy"},   {3'b000, busy},   {3'b000, bs});
        chk({tag, ".bypass"}, {3'b000, bypass}, {3'b000, b});
        chk({tag, ".fx_en"},  fx_en,            f);
        chk({tag, ".led"},    {3'b000, led},    {3'b000, ~b});
    endtask

    task automatic chk_rst(input string tag);
        chk_outs(tag, 1'b0, 1'b0, 1'b1, 4'b0000);
    endtask

    task automatic idle_tick(input string tag, input logic b, input logic [3:0] f);
        tick();
        chk_outs(tag, 1'b0, 1'b0, b, f);
    endtask

    // Step i of a sequence, i=0 being the sample where mute has just risen.
    task automatic seq_tick(input string tag, input int i, input logic b0, input logic [3:0] f0,
                            input logic b1, input logic [3:0] f1);
        logic       m;
        logic       b;
        logic [3:0] f;
        if (i > 0) tick();
        m = (i <= 2 * C_MC);
        b = (i <= C_MC) ? b0 : b1;
        f = (i <= C_MC) ? f0 : f1;
        chk_outs($sformatf("%s[%0d]", tag, i), m, m, b, f);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        fsw_n  = 1'b1;
        fx_sel = 2'd0;

        // Reset state and a quiet idle period.
        repeat (3) tick();
        chk_rst("t1_in_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) idle_tick("t1_idle", 1'b1, 4'b0000);

        // Select 2 plus a held press: one sequence, selection event starts it.
        fsw_n  = 1'b0;
        fx_sel = 2'd2;
        idle_tick("t2_pre", 1'b1, 4'b0000);
        idle_tick("t2_pre", 1'b1, 4'b0000);
        tick();
        for (int i = 0; i <= 17; i++) begin
            if (i == 8) fsw_n = 1'b1;
            seq_tick("t2", i, 1'b1, 4'b0000, 1'b0, 4'b0100);
        end
        for (int k = 0; k < 6; k++) idle_tick("t2_post", 1'b0, 4'b0100);

        // Bouncing footswitch never stays stable long enough.
        for (int k = 0; k < 40; k++) begin
            fsw_n = ((k / 2) % 2) != 0;
            idle_tick("t3_bounce", 1'b0, 4'b0100);
        end
        fsw_n = 1'b1;
        for (int k = 0; k < 10; k++) idle_tick("t3_hold", 1'b0, 4'b0100);

        // Select 1, change to 3 during SETTLE: back-to-back second sequence.
        fx_sel = 2'd1;
        idle_tick("t5_pre", 1'b0, 4'b0100);
        idle_tick("t5_pre", 1'b0, 4'b0100);
        tick();
        for (int i = 0; i <= 17; i++) begin
            if (i == 12) fx_sel = 2'd3;
            seq_tick("t5a", i, 1'b0, 4'b0100, 1'b0, 4'b0010);
        end
        tick();
        for (int i = 0; i <= 17; i++) seq_tick("t5b", i, 1'b0, 4'b0010, 1'b0, 4'b1000);
        for (int k = 0; k < 6; k++) idle_tick("t5_post", 1'b0, 4'b1000);

        // Two presses that cancel: debounced press at MUTE_RAMP entry and at its last edge.
        fsw_n = 1'b0;
        idle_tick("t4_pre", 1'b0, 4'b1000);
        idle_tick("t4_pre", 1'b0, 4'b1000);
        idle_tick("t4_pre", 1'b0, 4'b1000);
        fx_sel = 2'd1;
        idle_tick("t4_pre", 1'b0, 4'b1000);
        fsw_n = 1'b1;
        idle_tick("t4_pre", 1'b0, 4'b1000);
        tick();
        for (int i = 0; i <= 17; i++) begin
            if (i == 3) fsw_n = 1'b0;
            if (i == 7) fsw_n = 1'b1;
            seq_tick("t4", i, 1'b0, 4'b1000, 1'b0, 4'b0010);
        end
        for (int k = 0; k < 12; k++) idle_tick("t4_post", 1'b0, 4'b0010);

        // Reset pulse in MUTE_RAMP, then the leftover select runs with bypass kept.
        fx_sel = 2'd2;
        idle_tick("t6_pre", 1'b0, 4'b0010);
        idle_tick("t6_pre", 1'b0, 4'b0010);
        tick();
        for (int i = 0; i <= 3; i++) seq_tick("t6a", i, 1'b0, 4'b0010, 1'b0, 4'b0010);
        rst_n = 1'b0;
        tick();
        chk_rst("t6_rst");
        rst_n = 1'b1;
        idle_tick("t6_after_rst", 1'b1, 4'b0000);
        idle_tick("t6_after_rst", 1'b1, 4'b0000);
        tick();
        for (int i = 0; i <= 17; i++) seq_tick("t6b", i, 1'b1, 4'b0000, 1'b1, 4'b0000);
        for (int k = 0; k < 3; k++) idle_tick("t6b_post", 1'b1, 4'b0000);

        // Enable drop in SETTLE.
        fx_sel = 2'd3;
        idle_tick("t6c_pre", 1'b1, 4'b0000);
        idle_tick("t6c_pre", 1'b1, 4'b0000);
        tick();
        for (int i = 0; i <= 12; i++) seq_tick("t6c", i, 1'b1, 4'b0000, 1'b1, 4'b0000);
        ena    = 1'b0;
        fx_sel = 2'd0;
        tick();
        chk_rst("t6_ena");
        ena = 1'b1;
        for (int k = 0; k < 10; k++) idle_tick("t6_after_ena", 1'b1, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
